// File: rtl/sb_deserializer_framed_if.sv
// ---------------------------------------------------------------------------
// sb_deserializer_framed_if
// Bundles the serial-side inputs and the parallel-side outputs of the
// framed sideband deserializer.
//
//   enable        bit strobe; the line is sampled only when high
//   in_bit        serial line, idles at 1
//   flush         synchronous abort back to IDLE
//   parallel_data assembled word, first symbol in the low DATA_WIDTH bits
//   data_valid    one-cycle pulse: parallel_data is new
//   frame_err     one-cycle pulse: stop bit sampled as 0
//   busy          receiver is in any state other than IDLE
//
// Modports: master = line driver / word consumer, slave = deserializer.
// ---------------------------------------------------------------------------
interface sb_deserializer_framed_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SYMBOLS    = 1
);
    logic                          enable;
    logic                          in_bit;
    logic                          flush;
    logic [DATA_WIDTH*SYMBOLS-1:0] parallel_data;
    logic                          data_valid;
    logic                          frame_err;
    logic                          busy;

    modport master (
        output enable,
        output in_bit,
        output flush,
        input  parallel_data,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  enable,
        input  in_bit,
        input  flush,
        output parallel_data,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/sb_deserializer_framed.sv
// ---------------------------------------------------------------------------
// sb_deserializer_framed
// Sideband receive deserializer for start/stop-framed symbols. Each symbol
// is a 0 start bit, DATA_WIDTH data bits and a 1 stop bit, one bit per
// enabled clock. SYMBOLS good symbols are packed into one output word and
// announced with a one-cycle data_valid pulse; a bad stop bit gives a
// one-cycle frame_err pulse and drops the partial word.
//
// Ports:
//   clk  receive clock
//   rst  asynchronous active-low reset
//   sb   sb_deserializer_framed_if.slave (enable, in_bit, flush in;
//        parallel_data, data_valid, frame_err, busy out)
//
// States:
//   IDLE   | line idle, waiting for a 0 start bit
//   DATA   | shifting in DATA_WIDTH data bits
//   STOP   | sampling the stop bit, storing or rejecting the symbol
//   RESYNC | after a framing error, waiting for the line to return to 1
// ---------------------------------------------------------------------------
module sb_deserializer_framed #(
    parameter int DATA_WIDTH = 8,
    parameter int SYMBOLS    = 1,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    sb_deserializer_framed_if.slave sb
);
    localparam int BCW = $clog2(DATA_WIDTH);
    localparam int SCW = $clog2(SYMBOLS) + 1;
    localparam int WW  = DATA_WIDTH * SYMBOLS;

    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [SCW-1:0] SYM_LAST = SCW'(SYMBOLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2,
        RESYNC = 2'd3
    } state_t;

    state_t                state;
    logic [BCW-1:0]        bit_cnt;
    logic [SCW-1:0]        sym_cnt;
    logic [DATA_WIDTH-1:0] sym_reg;
    logic [WW-1:0]         word_reg;
    logic [WW-1:0]         pd_reg;
    logic                  dv_reg;
    logic                  fe_reg;

    logic [DATA_WIDTH-1:0] sym_shift;
    logic [WW-1:0]         word_next;

    // LSB-first shifts in from the top so the first bit ends up in bit 0
    // after DATA_WIDTH shifts; MSB-first shifts in from the bottom.
    always_comb begin
        if (LSB_FIRST)
            sym_shift = {sb.in_bit, sym_reg[DATA_WIDTH-1:1]};
        else
            sym_shift = {sym_reg[DATA_WIDTH-2:0], sb.in_bit};
    end

    // Word with the just-completed symbol dropped into its slot, so the
    // final symbol is included when the word is published on the same edge.
    always_comb begin
        word_next = word_reg;
        for (int s = 0; s < SYMBOLS; s++) begin
            if (sym_cnt == SCW'(s))
                word_next[s*DATA_WIDTH +: DATA_WIDTH] = sym_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sym_cnt  <= '0;
            sym_reg  <= '0;
            word_reg <= '0;
            pd_reg   <= '0;
            dv_reg   <= 1'b0;
            fe_reg   <= 1'b0;
        end else begin
            dv_reg <= 1'b0;
            fe_reg <= 1'b0;
            if (sb.flush) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                sym_cnt  <= '0;
                sym_reg  <= '0;
                word_reg <= '0;
            end else if (sb.enable) begin
                case (state)
                    IDLE: begin
                        if (!sb.in_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sym_reg <= sym_shift;
                        if (bit_cnt == BIT_LAST)
                            state <= STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                    STOP: begin
                        if (sb.in_bit) begin
                            state <= IDLE;
                            if (sym_cnt == SYM_LAST) begin
                                pd_reg   <= word_next;
                                dv_reg   <= 1'b1;
                                sym_cnt  <= '0;
                                word_reg <= '0;
                            end else begin
                                word_reg <= word_next;
                                sym_cnt  <= sym_cnt + 1'b1;
                            end
                        end else begin
                            state    <= RESYNC;
                            fe_reg   <= 1'b1;
                            sym_cnt  <= '0;
                            word_reg <= '0;
                        end
                    end
                    RESYNC: begin
                        // A 0 here is line noise, never a start bit.
                        if (sb.in_bit)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sb.parallel_data = pd_reg;
    assign sb.data_valid    = dv_reg;
    assign sb.frame_err     = fe_reg;
    assign sb.busy          = (state != IDLE);

endmodule

// File: tb/tb_sb_deserializer_framed.sv
// ---------------------------------------------------------------------------
// tb_sb_deserializer_framed
// Directed bench for sb_deserializer_framed. Three instances share one
// serial stream: u_s1 (8 bits, 1 symbol, LSB first), u_s2 (8 bits,
// 2 symbols, LSB first) and u_msb (8 bits, 1 symbol, MSB first).
// ---------------------------------------------------------------------------
module tb_sb_deserializer_framed;
    logic clk;
    logic rst;

    int n_assert;
    int n_fail;

    sb_deserializer_framed_if #(.DATA_WIDTH(8), .SYMBOLS(1)) if_s1  ();
    sb_deserializer_framed_if #(.DATA_WIDTH(8), .SYMBOLS(2)) if_s2  ();
    sb_deserializer_framed_if #(.DATA_WIDTH(8), .SYMBOLS(1)) if_msb ();

    sb_deserializer_framed #(.DATA_WIDTH(8), .SYMBOLS(1), .LSB_FIRST(1'b1)) u_s1 (
        .clk (clk),
        .rst (rst),
        .sb  (if_s1.slave)
    );

    sb_deserializer_framed #(.DATA_WIDTH(8), .SYMBOLS(2), .LSB_FIRST(1'b1)) u_s2 (
        .clk (clk),
        .rst (rst),
        .sb  (if_s2.slave)
    );

    sb_deserializer_framed #(.DATA_WIDTH(8), .SYMBOLS(1), .LSB_FIRST(1'b0)) u_msb (
        .clk (clk),
        .rst (rst),
        .sb  (if_msb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input logic en, input logic fl);
        if_s1.in_bit  = b;  if_s1.enable  = en; if_s1.flush  = fl;
        if_s2.in_bit  = b;  if_s2.enable  = en; if_s2.flush  = fl;
        if_msb.in_bit = b;  if_msb.enable = en; if_msb.flush = fl;
    endtask

    // One clock with the given line value; returns 1 time unit after the edge.
    task automatic step(input logic b);
        drive(b, 1'b1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // One enabled clock followed by one disabled clock with the bit held.
    task automatic step_half(input logic b);
        drive(b, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(b, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Start bit plus 8 data bits LSB first; the stop bit is left to the caller.
    task automatic send_body(input logic [7:0] d);
        step(1'b0);
        for (int i = 0; i < 8; i++) step(d[i]);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #3;
        chk("reset_pd",   {24'd0, if_s1.parallel_data}, 32'h0);
        chk("reset_dv",   {31'd0, if_s1.data_valid},    32'h0);
        chk("reset_fe",   {31'd0, if_s1.frame_err},     32'h0);
        chk("reset_busy", {31'd0, if_s1.busy},          32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic frame A5 after two idle bits; line bits are a palindrome so
        // the MSB-first instance also assembles A5.
        step(1'b1);
        step(1'b1);
        chk("t1_idle_busy", {31'd0, if_s1.busy}, 32'h0);
        step(1'b0);
        chk("t1_start_busy", {31'd0, if_s1.busy}, 32'h1);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        chk("t1_stop_busy", {31'd0, if_s1.busy},       32'h1);
        chk("t1_pre_dv",    {31'd0, if_s1.data_valid}, 32'h0);
        step(1'b1);
        chk("t1_dv",      {31'd0, if_s1.data_valid},    32'h1);
        chk("t1_pd",      {24'd0, if_s1.parallel_data}, 32'hA5);
        chk("t1_busy_end",{31'd0, if_s1.busy},          32'h0);
        chk("t5_msb_dv",  {31'd0, if_msb.data_valid},   32'h1);
        chk("t5_msb_pd",  {24'd0, if_msb.parallel_data},32'hA5);
        step(1'b1);
        chk("t1_dv_clear", {31'd0, if_s1.data_valid},    32'h0);
        chk("t1_pd_hold",  {24'd0, if_s1.parallel_data}, 32'hA5);

        // MSB-first with an asymmetric pattern: line 1,1,0,0,0,0,0,1 -> C1.
        do_reset();
        send_body(8'h83);
        step(1'b1);
        chk("t5_msb_pd_c1", {24'd0, if_msb.parallel_data}, 32'hC1);
        chk("t5_lsb_pd_83", {24'd0, if_s1.parallel_data},  32'h83);

        // Two symbols back-to-back into the 2-symbol instance.
        do_reset();
        send_body(8'hA5);
        step(1'b1);
        chk("t2_first_dv", {31'd0, if_s2.data_valid}, 32'h0);
        send_body(8'h3C);
        step(1'b1);
        chk("t2_dv", {31'd0, if_s2.data_valid},    32'h1);
        chk("t2_pd", {16'd0, if_s2.parallel_data}, 32'h3CA5);
        step(1'b1);
        chk("t2_dv_clear", {31'd0, if_s2.data_valid}, 32'h0);

        // Framing error, zeros in RESYNC ignored, then a good frame 11.
        do_reset();
        send_body(8'h5A);
        step(1'b0);
        chk("t3_fe",    {31'd0, if_s1.frame_err},     32'h1);
        chk("t3_no_dv", {31'd0, if_s1.data_valid},    32'h0);
        chk("t3_pd",    {24'd0, if_s1.parallel_data}, 32'h0);
        step(1'b0);
        chk("t3_fe_clear",   {31'd0, if_s1.frame_err}, 32'h0);
        chk("t3_resync_busy",{31'd0, if_s1.busy},      32'h1);
        step(1'b0);
        chk("t3_resync_hold",{31'd0, if_s1.busy},      32'h1);
        step(1'b1);
        chk("t3_back_idle",  {31'd0, if_s1.busy},      32'h0);
        send_body(8'h11);
        step(1'b1);
        chk("t3_dv", {31'd0, if_s1.data_valid},    32'h1);
        chk("t3_pd11", {24'd0, if_s1.parallel_data}, 32'h11);

        // Framing error discards a partial word in the 2-symbol instance.
        do_reset();
        send_body(8'h42);
        step(1'b1);
        send_body(8'h99);
        step(1'b0);
        step(1'b1);
        send_body(8'h12);
        step(1'b1);
        chk("t3_s2_no_dv", {31'd0, if_s2.data_valid}, 32'h0);
        send_body(8'h34);
        step(1'b1);
        chk("t3_s2_dv", {31'd0, if_s2.data_valid},    32'h1);
        chk("t3_s2_pd", {16'd0, if_s2.parallel_data}, 32'h3412);

        // Enable toggling 1,0 while sending C3.
        do_reset();
        step_half(1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] c3;
            c3 = 8'hC3;
            step_half(c3[i]);
        end
        chk("t4_pre_dv", {31'd0, if_s1.data_valid}, 32'h0);
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("t4_dv", {31'd0, if_s1.data_valid},    32'h1);
        chk("t4_pd", {24'd0, if_s1.parallel_data}, 32'hC3);
        drive(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("t4_dv_clear", {31'd0, if_s1.data_valid}, 32'h0);

        // Reset mid-symbol, then a fresh frame 7E.
        step(1'b0);
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        rst = 1'b0;
        #2;
        chk("t6_rst_pd",   {24'd0, if_s1.parallel_data}, 32'h0);
        chk("t6_rst_busy", {31'd0, if_s1.busy},          32'h0);
        chk("t6_rst_dv",   {31'd0, if_s1.data_valid},    32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1);
        send_body(8'h7E);
        step(1'b1);
        chk("t6_dv", {31'd0, if_s1.data_valid},    32'h1);
        chk("t6_pd", {24'd0, if_s1.parallel_data}, 32'h7E);

        // Flush on the stop-bit edge of frame 81.
        send_body(8'h81);
        drive(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("t7_flush_dv",   {31'd0, if_s1.data_valid},    32'h0);
        chk("t7_flush_pd",   {24'd0, if_s1.parallel_data}, 32'h7E);
        chk("t7_flush_busy", {31'd0, if_s1.busy},          32'h0);

        // Flush mid-frame, then a clean frame 24.
        step(1'b0);
        step(1'b0); step(1'b1);
        drive(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("t7_midflush_busy", {31'd0, if_s1.busy}, 32'h0);
        send_body(8'h24);
        step(1'b1);
        chk("t7_after_dv", {31'd0, if_s1.data_valid},    32'h1);
        chk("t7_after_pd", {24'd0, if_s1.parallel_data}, 32'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
